// File: rtl/img_stream_pkg.sv
// img_stream_pkg: shared pixel-stream types used by the frame streamer and the row/column PEs.
package img_stream_pkg;
    localparam int PIX_W = 8;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} strm_state_t;
    typedef struct packed {
        logic             eor;
        logic             eof;
        logic [PIX_W-1:0] data;
    } pix_beat_t;
endpackage

// File: rtl/stream_out_fifo.sv
// stream_out_fifo: 3-entry output FIFO of pixel beats with occupancy count.
module stream_out_fifo
    import img_stream_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  pix_beat_t  i_beat,
    input  logic       i_pop,
    output pix_beat_t  o_head,
    output logic [1:0] o_count
);
    pix_beat_t  mem [3];
    logic [1:0] wr_ptr, rd_ptr;
    logic       do_pop;
    assign do_pop = i_pop && (o_count != 2'd0);
    assign o_head = mem[rd_ptr];
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem     <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_beat;
                wr_ptr      <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            o_count <= (i_push && !do_pop) ? o_count + 2'd1 :
                       (!i_push && do_pop) ? o_count - 2'd1 : o_count;
        end
    end
endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: raster-order frame reader feeding a vld/rdy pixel stream with eor/eof tags.
// Optional inter-row issue gap enabled by defining FRAME_STREAMER_ROW_GAP_EN.
module frame_streamer
    import img_stream_pkg::*;
#(
    parameter int DATA_W  = PIX_W,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int ADDR_W  = $clog2(IMG_W*IMG_H),
    parameter int ROW_GAP = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_rdy,
    output logic              o_vld,
    output logic              o_eor,
    output logic              o_eof,
    output logic [DATA_W-1:0] o_data
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H+1);
    localparam int GAP_W = $clog2(ROW_GAP+2);
`ifdef FRAME_STREAMER_ROW_GAP_EN
    localparam logic [GAP_W-1:0] GAP_LEN = GAP_W'(ROW_GAP);
`else
    localparam logic [GAP_W-1:0] GAP_LEN = '0;
`endif

    strm_state_t      state, state_nx;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [GAP_W-1:0] gap;
    logic             inflight, fl_eor, fl_eof;
    logic [1:0]       fifo_cnt;
    pix_beat_t        head, beat_in;
    logic             issue, is_eor, is_eof, pop, eof_hs;

    // Credit covers both queued beats and the read still in the RAM pipe.
    assign is_eor   = col == COL_W'(IMG_W-1);
    assign is_eof   = is_eor && (row == ROW_W'(IMG_H-1));
    assign issue    = (state == STREAM) && (gap == '0) &&
                      (({1'b0, fifo_cnt} + {2'b0, inflight}) < 3'd3);
    assign o_mem_en = issue;
    assign o_vld    = fifo_cnt != 2'd0;
    assign pop      = o_vld && i_rdy;
    assign eof_hs   = pop && head.eof;
    assign o_busy   = state != IDLE;
    assign o_eor    = head.eor;
    assign o_eof    = head.eof;
    assign o_data   = DATA_W'(head.data);
    assign beat_in  = '{eor: fl_eor, eof: fl_eof, data: PIX_W'(i_mem_data)};

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE   && i_start)         ? STREAM :
                   (state == STREAM && issue && is_eof) ? DRAIN  :
                   (state == DRAIN  && eof_hs)          ? IDLE   : state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col        <= '0;
            row        <= '0;
            gap        <= '0;
            o_mem_addr <= '0;
            inflight   <= 1'b0;
            fl_eor     <= 1'b0;
            fl_eof     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            if (issue) begin
                col        <= is_eor ? '0 : col + 1'b1;
                row        <= is_eof ? '0 : (is_eor ? row + 1'b1 : row);
                o_mem_addr <= is_eof ? '0 : o_mem_addr + 1'b1;
            end
            if (issue && is_eor && !is_eof) gap <= GAP_LEN;
            else if (gap != '0)             gap <= gap - 1'b1;
            inflight <= issue;
            fl_eor   <= is_eor;
            fl_eof   <= is_eof;
            o_done   <= eof_hs;
        end
    end

    stream_out_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (inflight),
        .i_beat  (beat_in),
        .i_pop   (pop),
        .o_head  (head),
        .o_count (fifo_cnt)
    );
endmodule
